// File: rtl/blk_mem_gen_6_wrapper.sv
// Single-port write-first block RAM with registered read data and a synchronous active-high reset.
// Defining BLK_MEM_GEN_6_OUTPUT_REG_EN adds a second output register, which makes the read latency two cycles.
module blk_mem_gen_6_wrapper #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024
) (
  input  logic                  CLKA,
  input  logic                  RSTA,
  input  logic                  ENA,
  input  logic                  WEA,
  input  logic [ADDR_WIDTH-1:0] ADDRA,
  input  logic [DATA_WIDTH-1:0] DINA,
  output logic [DATA_WIDTH-1:0] DOUTA
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] dout_r = '0;
  logic [DATA_WIDTH-1:0] dout_next_s;
  logic                  in_range_s;

  // Flag addresses that fall outside the implemented depth
  always_comb begin
    in_range_s = (32'(ADDRA) < 32'(DEPTH));
  end

  // Select the word for the output register: write-first data, array data, or zero when out of range
  always_comb begin
    dout_next_s = '0;
    if (!in_range_s) begin
      dout_next_s = '0;
    end else if (WEA) begin
      dout_next_s = DINA;
    end else begin
      dout_next_s = mem_r[ADDRA];
    end
  end

  // Write the array; reset never clears the stored contents
  always_ff @(posedge CLKA) begin
    if (ENA && WEA && in_range_s) begin
      mem_r[ADDRA] <= DINA;
    end
  end

  // Capture the first output stage; reset takes priority over a read or write
  always_ff @(posedge CLKA) begin
    if (RSTA) begin
      dout_r <= '0;
    end else if (ENA) begin
      dout_r <= dout_next_s;
    end else begin
      dout_r <= dout_r;
    end
  end

`ifdef BLK_MEM_GEN_6_OUTPUT_REG_EN
  logic                  ena_d_r = 1'b0;
  logic [DATA_WIDTH-1:0] pipe_r  = '0;

  // Delayed enable: the second stage advances one cycle after an enabled access
  always_ff @(posedge CLKA) begin
    if (RSTA) begin
      ena_d_r <= 1'b0;
    end else begin
      ena_d_r <= ENA;
    end
  end

  // Capture the second output stage
  always_ff @(posedge CLKA) begin
    if (RSTA) begin
      pipe_r <= '0;
    end else if (ena_d_r) begin
      pipe_r <= dout_r;
    end else begin
      pipe_r <= pipe_r;
    end
  end

  assign DOUTA = pipe_r;
`else
  assign DOUTA = dout_r;
`endif

endmodule

// File: tb/tb_blk_mem_gen_6_wrapper.sv
// Directed bench for blk_mem_gen_6_wrapper. It drives a default 1024-deep instance and a 1000-deep
// instance in parallel, so that addresses at or above 1000 exercise the out-of-range behaviour.
module tb_blk_mem_gen_6_wrapper;

`ifdef BLK_MEM_GEN_6_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        wea = 1'b0;
  logic [9:0]  addr = 10'd0;
  logic [63:0] din = 64'd0;
  logic [63:0] dout;
  logic [63:0] dout_oor;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] BIG = 64'hDEADBEEF_CAFEF00D;

  blk_mem_gen_6_wrapper u_dut (
    .CLKA(clk), .RSTA(rst), .ENA(ena), .WEA(wea), .ADDRA(addr), .DINA(din), .DOUTA(dout)
  );

  blk_mem_gen_6_wrapper #(.DEPTH(1000)) u_oor (
    .CLKA(clk), .RSTA(rst), .ENA(ena), .WEA(wea), .ADDRA(addr), .DINA(din), .DOUTA(dout_oor)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus, then sample 1 time unit after the rising edge
  task automatic cyc(input logic r, input logic e, input logic w,
                     input logic [9:0] a, input logic [63:0] d);
    rst  = r;
    ena  = e;
    wea  = w;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles that let the optional second output stage catch up
  task automatic settle();
    for (int k = 0; k < LAT - 1; k++) cyc(1'b0, 1'b0, 1'b0, 10'd0, 64'd0);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #1;
    check("time0_dout", dout, 64'd0);
    check("time0_dout_oor", dout_oor, 64'd0);

    cyc(1'b1, 1'b0, 1'b0, 10'd0, 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 10'd0, 64'd0);
    check("reset_dout", dout, 64'd0);
    check("reset_dout_oor", dout_oor, 64'd0);

    // Fill addresses 0..4 with 5..9, then idle for two cycles
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 10'(i), 64'(i + 5));
    cyc(1'b0, 1'b0, 1'b0, 10'd0, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 10'd0, 64'd0);

    // Back-to-back reads return one word per cycle after the read latency
    for (int i = 0; i < 5 + LAT - 1; i++) begin
      if (i < 5) cyc(1'b0, 1'b1, 1'b0, 10'(i), 64'd0);
      else       cyc(1'b0, 1'b0, 1'b0, 10'd0, 64'd0);
      if (i >= LAT - 1) check("stream_read", dout, 64'(5 + i - (LAT - 1)));
    end

    // Write-first at the top address; it is out of range in the 1000-deep instance
    cyc(1'b0, 1'b1, 1'b1, 10'd1023, BIG);
    settle();
    check("write_first", dout, BIG);
    check("write_first_oor", dout_oor, 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 10'd1023, 64'd0);
    settle();
    check("read_1023", dout, BIG);

    // A write with the port disabled is ignored, and the output holds its value
    cyc(1'b0, 1'b0, 1'b1, 10'd3, 64'h55);
    check("ena0_hold_a", dout, BIG);
    cyc(1'b0, 1'b0, 1'b0, 10'd3, 64'd0);
    check("ena0_hold_b", dout, BIG);
    cyc(1'b0, 1'b1, 1'b0, 10'd3, 64'd0);
    settle();
    check("ena0_no_write", dout, 64'd8);
    cyc(1'b0, 1'b0, 1'b0, 10'd4, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 10'd4, 64'd0);
    check("ena0_hold_c", dout, 64'd8);

    // Reset clears the output path while the write in the same cycle still commits
    cyc(1'b0, 1'b1, 1'b0, 10'd4, 64'd0);
    settle();
    check("pre_reset_9", dout, 64'd9);
    cyc(1'b1, 1'b1, 1'b1, 10'd2, 64'h77);
    check("reset_out_zero", dout, 64'd0);
    check("reset_out_zero_oor", dout_oor, 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 10'd2, 64'd0);
    settle();
    check("write_during_reset", dout, 64'h77);

    // A location that was never written reads as zero
    cyc(1'b0, 1'b1, 1'b0, 10'd500, 64'd0);
    settle();
    check("unwritten_500", dout, 64'd0);

    // Address 1010 is valid in the 1024-deep instance and out of range in the 1000-deep one
    cyc(1'b0, 1'b1, 1'b1, 10'd1010, 64'h1);
    cyc(1'b0, 1'b1, 1'b0, 10'd1010, 64'd0);
    settle();
    check("oor_read_zero", dout_oor, 64'd0);
    check("inrange_1010", dout, 64'h1);
    for (int i = 0; i < 5 + LAT - 1; i++) begin
      if (i < 5) cyc(1'b0, 1'b1, 1'b0, 10'(i), 64'd0);
      else       cyc(1'b0, 1'b0, 1'b0, 10'd0, 64'd0);
      if (i >= LAT - 1) begin
        case (i - (LAT - 1))
          0:       check("oor_keep", dout_oor, 64'd5);
          1:       check("oor_keep", dout_oor, 64'd6);
          2:       check("oor_keep", dout_oor, 64'h77);
          3:       check("oor_keep", dout_oor, 64'd8);
          default: check("oor_keep", dout_oor, 64'd9);
        endcase
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
